exe_mem_req_buf: RTL and testbench
==================================

# exe_mem_req_buf

Parametrised memory-request stage sitting between the execute stage and the data SRAM-like bus. It accepts load/store operations from EXE with a valid/ready handshake and checks address alignment. It formats the byte strobes and the replicated write data, then queues up to DEPTH requests. Requests issue in order on a req/addr_ok interface, so EXE no longer stalls on a busy memory port. An exception or ertn flush discards every queued request that has not yet issued.

## Interface
- DATA_W, 32: bus data width, 32 or 64.
- DEPTH, 4: queue entries, power of two, ≥2.
- ADDR_W, 32: address width.
- clk  in  1  clock; one clock domain.
- resetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  EXE presents a memory op.
- in_ready  out  1  queue can accept this cycle.
- in_we  in  1  1 = store, 0 = load.
- in_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (only legal when DATA_W=64).
- in_addr  in  ADDR_W  byte address.
- in_wdata  in  DATA_W  store data, right-aligned.
- in_ale  out  1  combinational misalignment flag for the presented op.
- flush  in  1  excp_flush | ertn_flush.
- req  out  1  head entry valid toward memory.
- wr  out  1  head is a store.
- size  out  2  head size.
- addr  out  ADDR_W  head address.
- wstrb  out  DATA_W/8  head byte strobes; all zero for loads.
- wdata  out  DATA_W  head replicated write data.
- addr_ok  in  1  memory accepts the head this cycle.
- count  out  log2(DEPTH)+1  occupied entries.

## Operation
- OB = log2(DATA_W/8); off = in_addr[OB-1:0].
- Misalignment: in_ale = in_valid & (in_addr & ((1<<in_size)-1)) != 0.
- Enqueue when in_valid & in_ready & !in_ale & !flush. An op with in_ale=1 is never queued; EXE converts it to an ALE exception.
- in_ready = (count != DEPTH). It does not depend on addr_ok, so there is no same-cycle pass-through when the queue is full.
- Strobe: wstrb = in_we ? (((1<<(1<<in_size))-1) << off) : 0. Width is DATA_W/8 and the computation is truncated to that width.
- Data: the low 2^in_size bytes of in_wdata are replicated across DATA_W.
- Strobe and data are computed at enqueue and stored in the entry, so the outputs come straight from registers.
- Storage: DEPTH-entry circular buffer with wr_ptr and rd_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH. count is held separately, so a full queue is distinguishable from an empty one.
- Dequeue when req & addr_ok; rd_ptr advances.
- Enqueue and dequeue in the same cycle: count is unchanged and both pointers advance.
- Flush:
  - count, wr_ptr and rd_ptr return to 0 next cycle.
  - An enqueue presented in the flush cycle is dropped.
  - A head handshake (req & addr_ok) completing in the flush cycle still counts as issued, because memory has already accepted it. Only unissued entries are discarded.
- Outputs when empty: req=0; wr, size, addr, wstrb and wdata are driven 0.

## Timing
- Reset (async assert, sync release): count=0, pointers=0, req=0, all head outputs 0, in_ready=1.
- Enqueue-to-req latency is 1 cycle: an op accepted at edge N shows req=1 after edge N.
- Once req=1, the head outputs hold stable until addr_ok.
- Throughput is one enqueue and one issue per cycle.
- A full queue with addr_ok=1 frees a slot at the next edge; in_ready rises the following cycle.
- Reset asserted mid-operation clears all state immediately. Any in-flight req is abandoned and memory must be reset alongside.
- flush has priority over enqueue. req falls the cycle after flush, whatever count was.

## Configuration
- EXE_MEM_REQ_ALE_EN:
  - Defined: alignment checking and in_ale as specified above.
  - Undefined: in_ale is tied 0. Every op is enqueued with addr[OB-1:0] and strobes computed as if the address were aligned down to 1<<size, i.e. the low size address bits are forced to 0 in both the stored addr and off.

## Test plan
- Reset release, DATA_W=32: store byte to 0x1003 with in_wdata=0xAB → next cycle req=1, wr=1, size=0, wstrb=4'b1000, wdata=0xABABABAB, count=1. With addr_ok=1 → count=0 and req=0.
- DATA_W=64: store half to 0x106 with in_wdata=0x1234 → wstrb=8'b11000000, wdata=0x1234123412341234. Load word to 0x104 → wstrb=0, size=2.
- EXE_MEM_REQ_ALE_EN defined: store word to 0x1002 → in_ale=1, count stays 0, req stays 0. Undefined: same op → addr=0x1000, wstrb=4'b1111.
- DEPTH=4 with addr_ok held 0: after four enqueues, count=4 and in_ready=0, and a fifth op is not accepted. Raise addr_ok for one cycle with in_valid held → count=3, then 4 on the next accept. Ops must issue in enqueue order, and pointer wrap must be exercised.
- Queue holding 3 entries; flush asserted together with addr_ok=1 and a new in_valid → the head counts as issued, the new op is dropped, next cycle count=0 and req=0.
- Assert resetn=0 asynchronously mid-cycle with count=2 → req, count and all head outputs go to 0 before the next clock edge.

Source files
------------

// File: rtl/exe_mem_req_buf.sv
// In-order memory request queue between EXE and the data bus: alignment check,
// strobe/data formatting at enqueue, flush of unissued entries. Option: EXE_MEM_REQ_ALE_EN.
module exe_mem_req_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_we,
  input  logic [1:0]                 in_size,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [DATA_W-1:0]          in_wdata,
  output logic                       in_ale,
  input  logic                       flush,
  output logic                       req,
  output logic                       wr,
  output logic [1:0]                 size,
  output logic [ADDR_W-1:0]          addr,
  output logic [DATA_W/8-1:0]        wstrb,
  output logic [DATA_W-1:0]          wdata,
  input  logic                       addr_ok,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int SW = DATA_W / 8;
  localparam int OB = $clog2(SW);
  localparam int PW = $clog2(DEPTH);

  logic [3:0]        size_mask;
  logic [ADDR_W-1:0] eff_addr;
  logic [OB-1:0]     off;
  logic [7:0]        lanes;
  logic [SW+7:0]     lanes_shifted;
  logic [SW-1:0]     enq_strb;
  logic [DATA_W-1:0] enq_data;
  logic              enq;
  logic              deq;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic              mem_we   [DEPTH];
  logic [1:0]        mem_size [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [SW-1:0]     mem_strb [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  assign size_mask = (4'd1 << in_size) - 4'd1;

`ifdef EXE_MEM_REQ_ALE_EN
  assign eff_addr = in_addr;
  assign in_ale   = in_valid & ((in_addr[2:0] & size_mask[2:0]) != 3'd0);
`else
  // Without alignment checking the op is silently aligned down to its size.
  assign eff_addr = {in_addr[ADDR_W-1:3], in_addr[2:0] & ~size_mask[2:0]};
  assign in_ale   = 1'b0;
`endif

  assign off = eff_addr[OB-1:0];

  always_comb begin
    case (in_size)
      2'd0:    lanes = 8'h01;
      2'd1:    lanes = 8'h03;
      2'd2:    lanes = 8'h0F;
      default: lanes = 8'hFF;
    endcase
    lanes_shifted = {{SW{1'b0}}, lanes} << off;
    enq_strb      = in_we ? lanes_shifted[SW-1:0] : '0;
  end

  // Byte i of the bus takes source byte (i mod 2^size): replication of the low bytes.
  always_comb begin
    enq_data = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      int unsigned sel;
      sel = i & 32'(size_mask);
      enq_data[i*8 +: 8] = in_wdata[sel*8 +: 8];
    end
  end

  assign in_ready = (count != (PW+1)'(DEPTH));
  assign req      = (count != '0);
  assign enq      = in_valid & in_ready & ~in_ale & ~flush;
  assign deq      = req & addr_ok;

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_we[wr_ptr]   <= in_we;
      mem_size[wr_ptr] <= in_size;
      mem_addr[wr_ptr] <= eff_addr;
      mem_strb[wr_ptr] <= enq_strb;
      mem_data[wr_ptr] <= enq_data;
    end
  end

  // A head handshake in the flush cycle has already been taken by memory,
  // so clearing everything drops only the unissued entries.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      if (enq && !deq)      count <= count + (PW+1)'(1);
      else if (!enq && deq) count <= count - (PW+1)'(1);
    end
  end

  always_comb begin
    wr    = 1'b0;
    size  = '0;
    addr  = '0;
    wstrb = '0;
    wdata = '0;
    if (req) begin
      wr    = mem_we[rd_ptr];
      size  = mem_size[rd_ptr];
      addr  = mem_addr[rd_ptr];
      wstrb = mem_strb[rd_ptr];
      wdata = mem_data[rd_ptr];
    end
  end

endmodule

// File: tb/tb_exe_mem_req_buf.sv
// Directed bench for exe_mem_req_buf: a 32-bit and a 64-bit instance, both DEPTH=4.
module tb_exe_mem_req_buf;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        a_valid, a_we, a_flush, a_addr_ok;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;
  logic        a_ready, a_ale, a_req, a_wr;
  logic [1:0]  a_osize;
  logic [31:0] a_oaddr, a_odata;
  logic [3:0]  a_wstrb;
  logic [2:0]  a_count;

  logic        b_valid, b_we, b_flush, b_addr_ok;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic        b_ready, b_ale, b_req, b_wr;
  logic [1:0]  b_osize;
  logic [31:0] b_oaddr;
  logic [63:0] b_odata;
  logic [7:0]  b_wstrb;
  logic [2:0]  b_count;

  exe_mem_req_buf #(.DATA_W(32), .DEPTH(4), .ADDR_W(32)) u32 (
    .clk(clk), .resetn(resetn), .in_valid(a_valid), .in_ready(a_ready), .in_we(a_we),
    .in_size(a_size), .in_addr(a_addr), .in_wdata(a_wdata), .in_ale(a_ale), .flush(a_flush),
    .req(a_req), .wr(a_wr), .size(a_osize), .addr(a_oaddr), .wstrb(a_wstrb), .wdata(a_odata),
    .addr_ok(a_addr_ok), .count(a_count)
  );

  exe_mem_req_buf #(.DATA_W(64), .DEPTH(4), .ADDR_W(32)) u64 (
    .clk(clk), .resetn(resetn), .in_valid(b_valid), .in_ready(b_ready), .in_we(b_we),
    .in_size(b_size), .in_addr(b_addr), .in_wdata(b_wdata), .in_ale(b_ale), .flush(b_flush),
    .req(b_req), .wr(b_wr), .size(b_osize), .addr(b_oaddr), .wstrb(b_wstrb), .wdata(b_odata),
    .addr_ok(b_addr_ok), .count(b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    a_valid = 0; a_we = 0; a_flush = 0; a_addr_ok = 0; a_size = 0; a_addr = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_flush = 0; b_addr_ok = 0; b_size = 0; b_addr = 0; b_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({a_req, a_count, a_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL reset_ctl got req=%b count=%0d ready=%b want 0 0 1", a_req, a_count, a_ready);
    end
    n_checks++;
    if ({a_wr, a_osize, a_oaddr, a_wstrb, a_odata} !== '0) begin
      n_fail++; $display("FAIL reset_head got wr=%b size=%0d addr=%h strb=%b data=%h want all 0",
                         a_wr, a_osize, a_oaddr, a_wstrb, a_odata);
    end
    n_checks++;
    if ({b_req, b_count, b_ready, b_wstrb, b_odata} !== {1'b0, 3'd0, 1'b1, 8'd0, 64'd0}) begin
      n_fail++; $display("FAIL reset_64 got req=%b count=%0d ready=%b strb=%b data=%h", b_req, b_count, b_ready, b_wstrb, b_odata);
    end
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_store_byte();
    a_valid = 1; a_we = 1; a_size = 2'd0; a_addr = 32'h1003; a_wdata = 32'h0000_00AB;
    n_checks++;
    if (a_ale !== 1'b0) begin n_fail++; $display("FAIL sb_ale got %b want 0", a_ale); end
    tick();
    a_valid = 0;
    n_checks++;
    if ({a_req, a_wr, a_osize, a_count} !== {1'b1, 1'b1, 2'd0, 3'd1}) begin
      n_fail++; $display("FAIL sb_ctl got req=%b wr=%b size=%0d count=%0d want 1 1 0 1", a_req, a_wr, a_osize, a_count);
    end
    n_checks++;
    if ({a_oaddr, a_wstrb, a_odata} !== {32'h1003, 4'b1000, 32'hABAB_ABAB}) begin
      n_fail++; $display("FAIL sb_head got addr=%h strb=%b data=%h want 1003 1000 abababab", a_oaddr, a_wstrb, a_odata);
    end
    a_addr_ok = 1;
    tick();
    a_addr_ok = 0;
    n_checks++;
    if ({a_req, a_count, a_wstrb, a_odata} !== {1'b0, 3'd0, 4'd0, 32'd0}) begin
      n_fail++; $display("FAIL sb_issue got req=%b count=%0d strb=%b data=%h want empty", a_req, a_count, a_wstrb, a_odata);
    end
  endtask

  task automatic test_wide_bus();
    b_valid = 1; b_we = 1; b_size = 2'd1; b_addr = 32'h106; b_wdata = 64'h1234;
    tick();
    b_we = 0; b_size = 2'd2; b_addr = 32'h104;
    n_checks++;
    if ({b_req, b_wr, b_count, b_wstrb} !== {1'b1, 1'b1, 3'd1, 8'b1100_0000}) begin
      n_fail++; $display("FAIL w64_store got req=%b wr=%b count=%0d strb=%b want 1 1 1 11000000", b_req, b_wr, b_count, b_wstrb);
    end
    n_checks++;
    if (b_odata !== 64'h1234_1234_1234_1234) begin
      n_fail++; $display("FAIL w64_data got %h want 1234123412341234", b_odata);
    end
    tick();
    b_valid = 0; b_addr_ok = 1;
    n_checks++;
    if (b_count !== 3'd2) begin n_fail++; $display("FAIL w64_count got %0d want 2", b_count); end
    tick();
    n_checks++;
    if ({b_req, b_wr, b_osize, b_oaddr, b_wstrb} !== {1'b1, 1'b0, 2'd2, 32'h104, 8'd0}) begin
      n_fail++; $display("FAIL w64_load got req=%b wr=%b size=%0d addr=%h strb=%b want 1 0 2 104 0",
                         b_req, b_wr, b_osize, b_oaddr, b_wstrb);
    end
    tick();
    b_addr_ok = 0;
    n_checks++;
    if ({b_req, b_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL w64_drain got req=%b count=%0d want 0 0", b_req, b_count); end
  endtask

  task automatic test_misaligned();
    a_valid = 1; a_we = 1; a_size = 2'd2; a_addr = 32'h1002; a_wdata = 32'hDEAD_BEEF;
    #1;
`ifdef EXE_MEM_REQ_ALE_EN
    n_checks++;
    if (a_ale !== 1'b1) begin n_fail++; $display("FAIL ale_flag got %b want 1", a_ale); end
    tick();
    a_valid = 0;
    n_checks++;
    if ({a_req, a_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL ale_drop got req=%b count=%0d want 0 0", a_req, a_count); end
`else
    n_checks++;
    if (a_ale !== 1'b0) begin n_fail++; $display("FAIL ale_flag got %b want 0", a_ale); end
    tick();
    a_valid = 0;
    n_checks++;
    if ({a_req, a_count, a_oaddr, a_wstrb, a_odata} !== {1'b1, 3'd1, 32'h1000, 4'b1111, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL ale_align got req=%b count=%0d addr=%h strb=%b data=%h want 1 1 1000 1111 deadbeef",
                         a_req, a_count, a_oaddr, a_wstrb, a_odata);
    end
    a_addr_ok = 1;
    tick();
    a_addr_ok = 0;
`endif
  endtask

  task automatic test_full_order();
    a_we = 1; a_size = 2'd2; a_valid = 1;
    for (int k = 0; k < 4; k++) begin
      a_addr = 32'h10 * (k + 1); a_wdata = a_addr;
      tick();
    end
    a_addr = 32'h50; a_wdata = 32'h50;
    n_checks++;
    if ({a_count, a_ready} !== {3'd4, 1'b0}) begin n_fail++; $display("FAIL full_state got count=%0d ready=%b want 4 0", a_count, a_ready); end
    tick();
    n_checks++;
    if ({a_count, a_oaddr} !== {3'd4, 32'h10}) begin n_fail++; $display("FAIL full_block got count=%0d head=%h want 4 10", a_count, a_oaddr); end
    a_addr_ok = 1;
    tick();
    a_addr_ok = 0;
    n_checks++;
    if ({a_count, a_ready, a_oaddr} !== {3'd3, 1'b1, 32'h20}) begin
      n_fail++; $display("FAIL full_free got count=%0d ready=%b head=%h want 3 1 20", a_count, a_ready, a_oaddr);
    end
    tick();
    a_valid = 0;
    n_checks++;
    if (a_count !== 3'd4) begin n_fail++; $display("FAIL full_refill got count=%0d want 4", a_count); end
    a_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({a_oaddr, a_odata} !== {32'h20 + 32'h10 * k, 32'h20 + 32'h10 * k}) begin
        n_fail++; $display("FAIL order_%0d got addr=%h data=%h want %h", k, a_oaddr, a_odata, 32'h20 + 32'h10 * k);
      end
      tick();
    end
    a_addr_ok = 0;
    n_checks++;
    if ({a_req, a_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL order_empty got req=%b count=%0d want 0 0", a_req, a_count); end
  endtask

  task automatic test_flush();
    a_we = 1; a_size = 2'd2; a_valid = 1;
    for (int k = 0; k < 3; k++) begin
      a_addr = 32'h100 + 32'h4 * k; a_wdata = a_addr;
      tick();
    end
    a_addr = 32'h200; a_flush = 1; a_addr_ok = 1;
    n_checks++;
    if ({a_count, a_oaddr} !== {3'd3, 32'h100}) begin n_fail++; $display("FAIL flush_pre got count=%0d head=%h want 3 100", a_count, a_oaddr); end
    tick();
    a_flush = 0; a_addr_ok = 0; a_valid = 0;
    n_checks++;
    if ({a_req, a_count, a_oaddr} !== {1'b0, 3'd0, 32'd0}) begin
      n_fail++; $display("FAIL flush_post got req=%b count=%0d addr=%h want 0 0 0", a_req, a_count, a_oaddr);
    end
    tick();
    n_checks++;
    if ({a_req, a_count} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL flush_drop got req=%b count=%0d want 0 0", a_req, a_count); end
  endtask

  task automatic test_async_reset();
    a_we = 1; a_size = 2'd0; a_valid = 1;
    a_addr = 32'h301; a_wdata = 32'h5A; tick();
    a_addr = 32'h302; tick();
    a_valid = 0;
    n_checks++;
    if ({a_count, a_req} !== {3'd2, 1'b1}) begin n_fail++; $display("FAIL ares_pre got count=%0d req=%b want 2 1", a_count, a_req); end
    #1 resetn = 1'b0;
    #1;
    n_checks++;
    if ({a_req, a_count, a_wr, a_osize, a_oaddr, a_wstrb, a_odata} !== '0) begin
      n_fail++; $display("FAIL ares_clear got req=%b count=%0d wr=%b addr=%h strb=%b data=%h want all 0",
                         a_req, a_count, a_wr, a_oaddr, a_wstrb, a_odata);
    end
    #3 resetn = 1'b1;
    tick();
    n_checks++;
    if ({a_req, a_count, a_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL ares_post got req=%b count=%0d ready=%b want 0 0 1", a_req, a_count, a_ready);
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_wide_bus();
    test_misaligned();
    test_full_order();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
